// File: rtl/echo_pkg.sv
// Shared definitions for the echo engine: mode encodings, fill/run state and
// the saturation helper used by the output stage.
package echo_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS    = 2'b00,
      MODE_SINGLE    = 2'b01,
      MODE_MULTI_ADD = 2'b10,
      MODE_MULTI_SUB = 2'b11
   } echo_mode_t;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } echo_state_t;

   // Clamp a signed value into the range of a two's complement word of the given width.
   function automatic int saturate(input int value, input int width);
      int hi;
      int lo;
      hi = (1 << (width - 1)) - 1;
      lo = -(1 << (width - 1));
      if (value > hi) begin
         return hi;
      end
      if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay memory with a synchronous, read-first read port:
// a read and write to the same address in one cycle returns the old word.
module echo_delay_ram #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 13
) (
   input  logic              sysclk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Both ports live in one block so the read samples the pre-write contents.
   always_ff @(posedge sysclk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/echo_engine.sv
// Audio echo processor: offset-binary in, scaled delayed copy added from a
// circular buffer, saturated, offset-binary out two clocks after each strobe.
module echo_engine
   import echo_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int ADDR_W     = 13,
   parameter int GAIN_SHIFT = 1,
   parameter int OFFSET     = 512
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [1:0]        mode,
   input  logic [ADDR_W:0]   delay,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid
);

   localparam logic [DATA_W-1:0] OFFSET_C = DATA_W'(OFFSET);
   localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_D    = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

   logic                     dv_r;
   logic                     strb;
   logic                     stage_v;
   logic signed [DATA_W-1:0] x_r;
   echo_mode_t               mode_r;
   logic [ADDR_W:0]          d_r;
   logic [ADDR_W:0]          d_clamp;
   logic [ADDR_W:0]          fill_cnt;
   logic [ADDR_W-1:0]        wr_ptr;
   logic [ADDR_W-1:0]        rd_addr;
   echo_state_t              state;

   logic [DATA_W-1:0]        ram_q;
   logic signed [DATA_W-1:0] q_s;
   logic signed [DATA_W-1:0] echo;
   logic signed [DATA_W:0]   x_ext;
   logic signed [DATA_W:0]   e_ext;
   logic signed [DATA_W:0]   sum;
   logic signed [DATA_W-1:0] y_sat;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_en;

   assign strb = data_valid & ~dv_r;

   // Delay of zero is meaningless and anything past the buffer cannot be stored.
   always_comb begin
      d_clamp = delay;
      if (delay == '0) begin
         d_clamp = ONE_D;
      end else if (delay > DEPTH_C) begin
         d_clamp = DEPTH_C;
      end
   end

   // A delay of DEPTH wraps to wr_ptr itself, relying on the read-first RAM.
   assign rd_addr = wr_ptr - d_clamp[ADDR_W-1:0];

   echo_delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .sysclk  (sysclk),
      .rd_en   (strb),
      .rd_addr (rd_addr),
      .rd_data (ram_q),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data)
   );

   assign q_s = ram_q;

   // While refilling, the buffer may hold pre-reset or wrong-delay samples, so mute the echo.
   always_comb begin
      echo = '0;
      if (state == RUN) begin
         echo = q_s >>> GAIN_SHIFT;
      end
   end

   assign x_ext = {x_r[DATA_W-1], x_r};
   assign e_ext = {echo[DATA_W-1], echo};

   always_comb begin
      sum = x_ext;
      case (mode_r)
         MODE_SINGLE,
         MODE_MULTI_ADD: sum = x_ext + e_ext;
         MODE_MULTI_SUB: sum = x_ext - e_ext;
         default:        sum = x_ext;
      endcase
   end

   assign y_sat = DATA_W'(saturate(int'(sum), DATA_W));

   // Feed-forward modes store the dry sample; feedback modes store the wet result.
   always_comb begin
      wr_data = y_sat;
      if ((mode_r == MODE_BYPASS) || (mode_r == MODE_SINGLE)) begin
         wr_data = x_r;
      end
   end

   assign wr_en = stage_v & ~reset;

   // Edge detect, capture stage, fill/run FSM, pointer and output register.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         dv_r      <= 1'b0;
         stage_v   <= 1'b0;
         x_r       <= '0;
         mode_r    <= MODE_BYPASS;
         d_r       <= ONE_D;
         state     <= FILL;
         fill_cnt  <= '0;
         wr_ptr    <= '0;
         data_out  <= OFFSET_C;
         out_valid <= 1'b0;
      end else begin
         dv_r      <= data_valid;
         stage_v   <= strb;
         out_valid <= stage_v;

         if (strb) begin
            x_r    <= data_in - OFFSET_C;
            mode_r <= echo_mode_t'(mode);
            d_r    <= d_clamp;
            if (d_clamp != d_r) begin
               state    <= FILL;
               fill_cnt <= '0;
            end
         end

         if (stage_v) begin
            data_out <= y_sat + OFFSET_C;
            wr_ptr   <= wr_ptr + ONE_A;
            if (state == FILL) begin
               fill_cnt <= fill_cnt + ONE_D;
               if ((fill_cnt + ONE_D) == d_r) begin
                  state <= RUN;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_echo_engine.sv
// Randomised and directed bench for echo_engine, checked against a
// sample-history model of the echo rules.
module tb_echo_engine;

   localparam int DATA_W     = 10;
   localparam int ADDR_W     = 13;
   localparam int GAIN_SHIFT = 1;
   localparam int OFFSET     = 512;
   localparam int DEPTH      = 2 ** ADDR_W;

   logic              sysclk;
   logic              reset;
   logic              data_valid;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        mode;
   logic [ADDR_W:0]   delay;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;

   int checks;
   int errors;

   // Every stored sample since reset, oldest first, plus the refill tracker.
   int hist[$];
   int since;
   int prev_d;

   echo_engine #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .GAIN_SHIFT (GAIN_SHIFT),
      .OFFSET     (OFFSET)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .data_valid (data_valid),
      .data_in    (data_in),
      .mode       (mode),
      .delay      (delay),
      .data_out   (data_out),
      .out_valid  (out_valid)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic checkOutput(input string tag, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
      end
   endtask

   function automatic void resetModel();
      hist.delete();
      since  = 0;
      prev_d = 1;
   endfunction

   // Echo is heard only once a full delay's worth of samples has been stored
   // since the last reset or delay change.
   function automatic int modelStep(input int din, input int m, input int dly);
      int x, d, e, y;
      x = din - OFFSET;
      d = (dly == 0) ? 1 : ((dly > DEPTH) ? DEPTH : dly);
      if (d != prev_d) begin
         since  = 0;
         prev_d = d;
      end
      e = 0;
      if (since >= d) begin
         e = hist[hist.size() - d] >>> GAIN_SHIFT;
      end
      since++;
      case (m)
         0:       y = x;
         3:       y = x - e;
         default: y = x + e;
      endcase
      if (y > OFFSET - 1) y = OFFSET - 1;
      if (y < -OFFSET)    y = -OFFSET;
      hist.push_back((m < 2) ? x : y);
      return y + OFFSET;
   endfunction

   task automatic applyStimulus(input int din, input int m, input int dly, output int got);
      int expv;
      expv = modelStep(din, m, dly);
      @(negedge sysclk);
      checkOutput("ov_idle", out_valid, 0);
      data_in    = DATA_W'(din);
      mode       = 2'(m);
      delay      = (ADDR_W + 1)'(dly);
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      checkOutput("ov_early", out_valid, 0);
      @(negedge sysclk);
      checkOutput("ov_pulse", out_valid, 1);
      got = data_out;
      checkOutput("dout", data_out, expv);
   endtask

   task automatic doReset();
      @(negedge sysclk);
      reset      = 1'b1;
      data_valid = 1'b0;
      @(negedge sysclk);
      reset = 1'b0;
      resetModel();
   endtask

   initial begin
      int got;
      int din;
      int m;
      int cur_d;
      int t2_in  [5] = '{612, 512, 512, 512, 512};
      int t2_exp [5] = '{612, 512, 512, 512, 562};
      int t3_exp [7] = '{768, 512, 640, 512, 576, 512, 544};
      int t5_in  [5];

      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = '0;
      mode       = 2'b00;
      delay      = '0;
      resetModel();
      repeat (3) @(negedge sysclk);
      checkOutput("rst_dout", data_out, OFFSET);
      checkOutput("rst_ov", out_valid, 0);
      reset = 1'b0;

      $display("[TB] bypass");
      applyStimulus(700, 0, 1, got);
      checkOutput("t1_bypass", got, 700);
      applyStimulus(100, 0, 1, got);
      checkOutput("t1_bypass2", got, 100);

      $display("[TB] single echo");
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(t2_in[i], 1, 4, got);
         checkOutput("t2_single", got, t2_exp[i]);
      end

      $display("[TB] multi echo");
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus((i == 0) ? 768 : 512, 2, 2, got);
         checkOutput("t3_add", got, t3_exp[i]);
      end
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i == 0) ? 768 : 512, 3, 2, got);
      end

      $display("[TB] saturation");
      doReset();
      applyStimulus(1023, 1, 1, got);
      applyStimulus(1023, 1, 1, got);
      checkOutput("t4_sat_hi", got, 1023);
      applyStimulus(0, 1, 1, got);
      applyStimulus(0, 1, 1, got);
      checkOutput("t4_sat_lo", got, 0);

      $display("[TB] delay change");
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom_range(0, 1023), 1, 4, got);
      end
      for (int i = 0; i < 5; i++) begin
         t5_in[i] = $urandom_range(0, 1023);
         applyStimulus(t5_in[i], 1, 3, got);
         if (i < 3) begin
            checkOutput("t5_refill", got, t5_in[i]);
         end
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus($urandom_range(0, 1023), 1, (i < 3) ? 0 : 1, got);
      end

      $display("[TB] reset interactions");
      applyStimulus(900, 1, 1, got);
      @(negedge sysclk);
      data_in    = 10'd300;
      mode       = 2'b01;
      delay      = (ADDR_W + 1)'(1);
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      reset      = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      resetModel();
      checkOutput("t6_abort_ov", out_valid, 0);
      checkOutput("t6_abort_dout", data_out, OFFSET);
      @(negedge sysclk);
      checkOutput("t6_abort_ov2", out_valid, 0);
      @(negedge sysclk);
      data_in    = 10'd900;
      data_valid = 1'b1;
      reset      = 1'b1;
      @(negedge sysclk);
      reset      = 1'b0;
      data_valid = 1'b0;
      resetModel();
      @(negedge sysclk);
      checkOutput("t6_rst_wins_ov", out_valid, 0);
      checkOutput("t6_rst_wins_dout", data_out, OFFSET);
      applyStimulus(700, 1, 1, got);
      checkOutput("t6_fill_after", got, 700);

      $display("[TB] full-depth delay and pointer wrap");
      doReset();
      for (int i = 0; i < DEPTH + 6; i++) begin
         applyStimulus($urandom_range(0, 1023), 1, (i % 2 == 1) ? 9000 : DEPTH, got);
      end

      $display("[TB] random");
      doReset();
      cur_d = 3;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            cur_d = $urandom_range(0, 20);
         end
         m   = $urandom_range(0, 3);
         din = $urandom_range(0, 1023);
         applyStimulus(din, m, cur_d, got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
